// File: rtl/ped_request_ctrl_if.sv
// rtl/ped_request_ctrl_if.sv - pedestrian controller signal bundle
//
// Groups the pedestrian button, the returned traffic light code and the
// controller outputs.
// modport master : environment side (drives ped_button, traffic_light)
// modport slave  : controller side (drives hold_red, walk, dont_walk,
//                  req_pending, seq_err)
interface ped_request_ctrl_if;
    logic       ped_button;
    logic [1:0] traffic_light;
    logic       hold_red;
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
    logic       seq_err;

    modport master (
        output ped_button, traffic_light,
        input  hold_red, walk, dont_walk, req_pending, seq_err
    );

    modport slave (
        input  ped_button, traffic_light,
        output hold_red, walk, dont_walk, req_pending, seq_err
    );
endinterface

// File: rtl/ped_request_ctrl.sv
// rtl/ped_request_ctrl.sv - pedestrian request controller for the traffic light FSM
//
// Synchronises and debounces the pedestrian button, holds the traffic FSM in
// RED, times WALK / CLEAR and enforces a green lockout before the next request.
// Optional feature macro: PED_FLASH_EN (flashing dont_walk during CLEAR).
// Ports:
//   clk_main   - main clock
//   rst_main_n - asynchronous active-low reset
//   ped_bus    - ped_request_ctrl_if.slave: ped_button, traffic_light in;
//                hold_red, walk, dont_walk, req_pending, seq_err out
module ped_request_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int WALK_CYCLES      = 8,
    parameter int CLEAR_CYCLES     = 4,
    parameter int MIN_GREEN_CYCLES = 6,
    parameter int FLASH_CYCLES     = 2
) (
    input  logic                  clk_main,
    input  logic                  rst_main_n,
    ped_request_ctrl_if.slave     ped_bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WALK    = 3'd2,
        S_CLEAR   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    localparam logic [1:0]  LIGHT_RED  = 2'b10;
    localparam logic [15:0] DEB_MAX    = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] WALK_LAST  = 16'(WALK_CYCLES - 1);
    localparam logic [15:0] CLEAR_LAST = 16'(CLEAR_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST  = 16'(MIN_GREEN_CYCLES - 1);

    logic        sync1_q, sync2_q;
    logic [15:0] deb_cnt_q, deb_cnt_d;
    logic        press_evt;

    state_t      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic        req_pending_q, req_pending_d;
    logic        seq_err_q, seq_err_d;
    logic        hold_red_q, hold_red_d;
    logic        walk_q, walk_d;
    logic        dont_walk_q, dont_walk_d;
`ifdef PED_FLASH_EN
    localparam logic [15:0] FLASH_LAST = 16'(FLASH_CYCLES - 1);
    logic [15:0] flash_cnt_q, flash_cnt_d;
    logic        flash_lvl_q, flash_lvl_d;
`endif

    // Button synchroniser and debounce counter
    always_ff @(posedge clk_main or negedge rst_main_n) begin
        if (!rst_main_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_cnt_q <= 16'd0;
        end else begin
            sync1_q   <= ped_bus.ped_button;
            sync2_q   <= sync1_q;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // The event fires on the edge where the count reaches DEBOUNCE_CYCLES;
    // saturation keeps it to one event per high period.
    always_comb begin
        press_evt = sync2_q && (deb_cnt_q == DEB_LAST);
        deb_cnt_d = deb_cnt_q;
        if (!sync2_q)
            deb_cnt_d = 16'd0;
        else if (deb_cnt_q != DEB_MAX)
            deb_cnt_d = deb_cnt_q + 16'd1;
    end

    // State register; outputs are registered from next-state decode
    always_ff @(posedge clk_main or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q       <= S_IDLE;
            phase_q       <= 16'd0;
            req_pending_q <= 1'b0;
            seq_err_q     <= 1'b0;
            hold_red_q    <= 1'b0;
            walk_q        <= 1'b0;
            dont_walk_q   <= 1'b1;
`ifdef PED_FLASH_EN
            flash_cnt_q   <= 16'd0;
            flash_lvl_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            req_pending_q <= req_pending_d;
            seq_err_q     <= seq_err_d;
            hold_red_q    <= hold_red_d;
            walk_q        <= walk_d;
            dont_walk_q   <= dont_walk_d;
`ifdef PED_FLASH_EN
            flash_cnt_q   <= flash_cnt_d;
            flash_lvl_q   <= flash_lvl_d;
`endif
        end
    end

    // Next-state logic; phase counter restarts at 0 on every phase entry
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (req_pending_q)
                    state_d = S_REQ;
            end
            S_REQ: begin
                if (ped_bus.traffic_light == LIGHT_RED) begin
                    state_d = S_WALK;
                    phase_d = 16'd0;
                end
            end
            S_WALK: begin
                if (phase_q == WALK_LAST) begin
                    state_d = S_CLEAR;
                    phase_d = 16'd0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            S_CLEAR: begin
                if (phase_q == CLEAR_LAST) begin
                    state_d = S_LOCKOUT;
                    phase_d = 16'd0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            S_LOCKOUT: begin
                if (phase_q == LOCK_LAST) begin
                    state_d = S_IDLE;
                    phase_d = 16'd0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 16'd0;
            end
        endcase

        // WALK entry clears the request; presses while in WALK are dropped
        req_pending_d = req_pending_q;
        if (state_d == S_WALK)
            req_pending_d = 1'b0;
        else if (press_evt && (state_q != S_WALK))
            req_pending_d = 1'b1;

        seq_err_d = seq_err_q;
        if (((state_q == S_WALK) || (state_q == S_CLEAR)) &&
            (ped_bus.traffic_light != LIGHT_RED))
            seq_err_d = 1'b1;

`ifdef PED_FLASH_EN
        // Flash phase starts low on CLEAR entry and toggles every FLASH_CYCLES
        flash_cnt_d = 16'd0;
        flash_lvl_d = 1'b0;
        if ((state_d == S_CLEAR) && (state_q == S_CLEAR)) begin
            if (flash_cnt_q == FLASH_LAST) begin
                flash_lvl_d = ~flash_lvl_q;
            end else begin
                flash_cnt_d = flash_cnt_q + 16'd1;
                flash_lvl_d = flash_lvl_q;
            end
        end
`endif
    end

    // Output decode from the next state so the lamps change with the state
    always_comb begin
        hold_red_d  = 1'b0;
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        case (state_d)
            S_REQ: hold_red_d = 1'b1;
            S_WALK: begin
                hold_red_d  = 1'b1;
                walk_d      = 1'b1;
                dont_walk_d = 1'b0;
            end
            S_CLEAR: begin
                hold_red_d  = 1'b1;
`ifdef PED_FLASH_EN
                dont_walk_d = flash_lvl_d;
`else
                dont_walk_d = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign ped_bus.hold_red    = hold_red_q;
    assign ped_bus.walk        = walk_q;
    assign ped_bus.dont_walk   = dont_walk_q;
    assign ped_bus.req_pending = req_pending_q;
    assign ped_bus.seq_err     = seq_err_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// tb/tb_ped_request_ctrl.sv - directed self-checking bench for ped_request_ctrl
module tb_ped_request_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button;
    logic [1:0] light;
    bit         force_on;
    logic [1:0] force_val;
    int         n_checks = 0;
    int         n_fail   = 0;

    ped_request_ctrl_if bus ();

    assign bus.ped_button    = button;
    assign bus.traffic_light = light;

    ped_request_ctrl dut (
        .clk_main   (clk),
        .rst_main_n (rst_n),
        .ped_bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock, then advance the traffic light model: it walks G->Y->R while
    // hold_red is high and returns to green otherwise.
    task automatic tick;
        @(posedge clk);
        #1;
        if (force_on)
            light = force_val;
        else if (bus.hold_red)
            light = (light == 2'b00) ? 2'b01 : 2'b10;
        else
            light = 2'b00;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hold"},  16'(bus.hold_red),    16'd0);
        check({tag, "_walk"},  16'(bus.walk),        16'd0);
        check({tag, "_dw"},    16'(bus.dont_walk),   16'd1);
        check({tag, "_pend"},  16'(bus.req_pending), 16'd0);
        check({tag, "_err"},   16'(bus.seq_err),     16'd0);
    endtask

    // Entered on the cycle hold_red is first seen high. Runs one full service
    // and returns either at REQ of the next service (press_lock) or after
    // 12 idle samples.
    task automatic service(input int btn_on, input int btn_off, input int force_n,
                           input bit press_lock, input bit exp_err, input string nm);
        int k;
        int n;
        int m;
        logic [3:0] dw;
`ifdef PED_FLASH_EN
        dw = 4'b1100;
`else
        dw = 4'b1111;
`endif
        k = 0;
        while (!bus.walk && k < 10) begin
            tick;
            k++;
        end
        check({nm, "_walk_start"}, 16'(bus.walk), 16'd1);
        n = 0;
        while (bus.walk && n < 20) begin
            n++;
            check({nm, "_walk_dw"}, 16'(bus.dont_walk), 16'd0);
            if (n == btn_on)  button = 1'b1;
            if (n == btn_off) button = 1'b0;
            if (force_n != 0 && n == force_n - 1) begin
                force_on  = 1'b1;
                force_val = 2'b00;
            end
            if (force_n != 0 && n == force_n) begin
                force_on = 1'b0;
                check({nm, "_err_before"}, 16'(bus.seq_err), 16'd0);
            end
            if (force_n != 0 && n == force_n + 1)
                check({nm, "_err_set"}, 16'(bus.seq_err), 16'd1);
            tick;
        end
        check({nm, "_walk_len"}, 16'(n), 16'd8);
        check({nm, "_pend_at_clear"}, 16'(bus.req_pending), 16'd0);
        for (int i = 0; i < 4; i++) begin
            check({nm, "_clr_hold"}, 16'(bus.hold_red),  16'd1);
            check({nm, "_clr_walk"}, 16'(bus.walk),      16'd0);
            check({nm, "_clr_dw"},   16'(bus.dont_walk), 16'(dw[i]));
            tick;
        end
        m = 0;
        while (!bus.hold_red && m < 12) begin
            m++;
            if (press_lock && m == 1) button = 1'b1;
            if (press_lock && m == 6) check({nm, "_lock_pend0"}, 16'(bus.req_pending), 16'd0);
            if (press_lock && m == 7) begin
                check({nm, "_lock_pend1"}, 16'(bus.req_pending), 16'd1);
                button = 1'b0;
            end
            check({nm, "_lock_dw"}, 16'(bus.dont_walk), 16'd1);
            tick;
        end
        if (press_lock) begin
            check({nm, "_lock_len"}, 16'(m), 16'd7);
            check({nm, "_req_hold"}, 16'(bus.hold_red), 16'd1);
        end else begin
            check({nm, "_idle_len"}, 16'(m), 16'd12);
            check({nm, "_idle_pend"}, 16'(bus.req_pending), 16'd0);
        end
        check({nm, "_err_end"}, 16'(bus.seq_err), 16'(exp_err));
    endtask

    initial begin
        int k;
        rst_n     = 1'b0;
        button    = 1'b0;
        light     = 2'b00;
        force_on  = 1'b0;
        force_val = 2'b00;

        // Reset
        repeat (3) tick;
        check_reset_vals("rst");
        #2 rst_n = 1'b1;
        tick;
        check_reset_vals("post_rst");

        // Glitch rejection: 3 high samples never reach the debounce count
        button = 1'b1;
        repeat (3) tick;
        button = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("glitch_pend", 16'(bus.req_pending), 16'd0);
            check("glitch_hold", 16'(bus.hold_red),    16'd0);
            tick;
        end

        // Full service with a 10-cycle press
        button = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick;
            if (e == 5) check("press_pend_e5", 16'(bus.req_pending), 16'd0);
            if (e == 6) begin
                check("press_pend_e6", 16'(bus.req_pending), 16'd1);
                check("press_hold_e6", 16'(bus.hold_red),    16'd0);
            end
            if (e == 7) check("press_hold_e7", 16'(bus.hold_red), 16'd1);
        end
        service(0, 2, 0, 1'b0, 1'b0, "svc1");

        // Press during WALK is dropped, press during LOCKOUT is kept
        button = 1'b1;
        repeat (7) tick;
        button = 1'b0;
        check("svc2_hold", 16'(bus.hold_red), 16'd1);
        service(1, 7, 0, 1'b1, 1'b0, "svc2");

        // Sequence error: light forced green on WALK cycle 3
        service(0, 0, 3, 1'b0, 1'b1, "svc3");

        // Asynchronous reset mid-WALK
        button = 1'b1;
        repeat (7) tick;
        button = 1'b0;
        k = 0;
        while (!bus.walk && k < 10) begin
            tick;
            k++;
        end
        check("mid_walk",  16'(bus.walk),    16'd1);
        check("mid_err",   16'(bus.seq_err), 16'd1);
        #3 rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        #2 rst_n = 1'b1;
        repeat (4) tick;
        check_reset_vals("after_async");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
